// File: rtl/pc_seq_pkg.sv
// Shared types and address helpers for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    // Clear the sub-line bits so the PC always points at a line start.
    function automatic int align_addr(input int addr, input int unsigned step);
        return addr & ~int'(step - 32'd1);
    endfunction

    // Single add/subtract of the address-space size to fold a target back in range.
    function automatic int wrap_addr(input int target, input int unsigned max_count);
        int m;
        m = int'(max_count);
        if (target < 0) begin
            return target + m;
        end else if (target >= m) begin
            return target - m;
        end
        return target;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between line fetch logic (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int unsigned NUMBER_LINES = 256,
    parameter int unsigned STEP         = 4
);
    localparam int unsigned ADDR_W = $clog2(NUMBER_LINES * STEP);
    localparam int unsigned LINE_W = $clog2(NUMBER_LINES);

    logic              start;
    logic              halt;
    logic              en;
    logic              hold;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic              branch;
    logic [ADDR_W:0]   offset;
    logic [ADDR_W-1:0] pc;
    logic [LINE_W-1:0] line;
    logic              running;
    logic              wrap;
    logic              done;
    logic              fault;

    modport master (
        output start, halt, en, hold, load, load_addr, branch, offset,
        input  pc, line, running, wrap, done, fault
    );

    modport slave (
        input  start, halt, en, hold, load, load_addr, branch, offset,
        output pc, line, running, wrap, done, fault
    );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: run-time priority mux, signed branch add,
// alignment and range correction with an out-of-range flag.
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter  int unsigned NUMBER_LINES = 256,
    parameter  int unsigned STEP         = 4,
    localparam int unsigned MAX_COUNT    = NUMBER_LINES * STEP,
    localparam int unsigned ADDR_W       = $clog2(MAX_COUNT)
) (
    input  logic              hold,
    input  logic              halt,
    input  logic              load,
    input  logic              branch,
    input  logic              en,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   offset,
    output logic [ADDR_W-1:0] next_pc_c,
    output logic              jump_c,
    output logic              step_c,
    output logic              last_line_c,
    output logic              out_of_range_c
);
    localparam int unsigned EXT_W = ADDR_W + 2;

    logic signed [EXT_W-1:0] branch_sum;
    logic signed [EXT_W-1:0] raw_target;
    int                      aligned;
    int                      folded;

    always_comb begin
        jump_c         = !hold && !halt && (load || branch);
        step_c         = !hold && !halt && !load && !branch && en;
        last_line_c    = (pc == ADDR_W'(MAX_COUNT - STEP));
        // Two guard bits keep both negative and past-the-end sums representable.
        branch_sum     = $signed({2'b00, pc}) + $signed({offset[ADDR_W], offset});
        raw_target     = load ? $signed({2'b00, load_addr}) : branch_sum;
        aligned        = align_addr(32'(raw_target), STEP);
        folded         = wrap_addr(aligned, MAX_COUNT);
        out_of_range_c = jump_c && (folded != aligned);
        next_pc_c      = pc;
        if (jump_c) begin
            next_pc_c = ADDR_W'(folded);
        end else if (step_c) begin
            next_pc_c = last_line_c ? '0 : pc + ADDR_W'(STEP);
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with IDLE/RUN/HALTED run control.
// Optional bounds checking on load/branch targets: define PC_BOUNDS_CHECK_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned NUMBER_LINES = 256,
    parameter int unsigned STEP         = 4,
    parameter int unsigned WRAP         = 1
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(NUMBER_LINES * STEP);
    localparam int unsigned LINE_W = $clog2(NUMBER_LINES);
    localparam int unsigned SHIFT  = $clog2(STEP);

    pc_state_t         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              running_q;
    logic              wrap_q;
    logic              done_q;

    logic [ADDR_W-1:0] next_pc_c;
    logic              jump_c;
    logic              step_c;
    logic              last_line_c;
    logic              out_of_range_c;

    pc_target_calc #(
        .NUMBER_LINES (NUMBER_LINES),
        .STEP         (STEP)
    ) u_target_calc (
        .hold           (bus.hold),
        .halt           (bus.halt),
        .load           (bus.load),
        .branch         (bus.branch),
        .en             (bus.en),
        .pc             (pc_q),
        .load_addr      (bus.load_addr),
        .offset         (bus.offset),
        .next_pc_c      (next_pc_c),
        .jump_c         (jump_c),
        .step_c         (step_c),
        .last_line_c    (last_line_c),
        .out_of_range_c (out_of_range_c)
    );

`ifdef PC_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
    logic fault_q;

    // Sticky fault: set by a rejected jump, cleared only by a new run or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (state_q != RUN && bus.start) begin
            fault_q <= 1'b0;
        end else if (state_q == RUN && jump_c && out_of_range_c) begin
            fault_q <= 1'b1;
        end
    end
    assign bus.fault = fault_q;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
    assign bus.fault = 1'b0;
`endif

    // Run-control FSM and PC register; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        pc_q      <= '0;
                    end
                end
                RUN: begin
                    if (bus.hold) begin
                        state_q <= RUN;
                    end else if (bus.halt) begin
                        state_q   <= HALTED;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (jump_c) begin
                        if (BOUNDS_CHECK && out_of_range_c) begin
                            state_q   <= HALTED;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            pc_q <= next_pc_c;
                        end
                    end else if (step_c) begin
                        // Without wrapping, stepping off the last line ends the program.
                        if (last_line_c && WRAP == 0) begin
                            state_q   <= HALTED;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            pc_q   <= next_pc_c;
                            wrap_q <= last_line_c;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc      = pc_q;
    assign bus.line    = LINE_W'(pc_q >> SHIFT);
    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: default config, WRAP=0 with 10 lines, and 10-line wrap config.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int          sel;
    logic        st, ha, en, ho, ld, br;
    logic [9:0]  la;
    logic [10:0] of;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [9:0] pc;
        logic       run;
        logic       wrap;
        logic       done;
        logic       fault;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    pc_sequencer_if #(.NUMBER_LINES(256), .STEP(4)) bus_a ();
    pc_sequencer_if #(.NUMBER_LINES(10),  .STEP(4)) bus_b ();
    pc_sequencer_if #(.NUMBER_LINES(10),  .STEP(4)) bus_c ();

    pc_sequencer #(.NUMBER_LINES(256), .STEP(4), .WRAP(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pc_sequencer #(.NUMBER_LINES(10),  .STEP(4), .WRAP(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    pc_sequencer #(.NUMBER_LINES(10),  .STEP(4), .WRAP(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    assign bus_a.start = (sel == 0) && st;  assign bus_a.halt   = (sel == 0) && ha;
    assign bus_a.en    = (sel == 0) && en;  assign bus_a.hold   = (sel == 0) && ho;
    assign bus_a.load  = (sel == 0) && ld;  assign bus_a.branch = (sel == 0) && br;
    assign bus_a.load_addr = (sel == 0) ? la : '0;
    assign bus_a.offset    = (sel == 0) ? of : '0;

    assign bus_b.start = (sel == 1) && st;  assign bus_b.halt   = (sel == 1) && ha;
    assign bus_b.en    = (sel == 1) && en;  assign bus_b.hold   = (sel == 1) && ho;
    assign bus_b.load  = (sel == 1) && ld;  assign bus_b.branch = (sel == 1) && br;
    assign bus_b.load_addr = (sel == 1) ? 6'(la) : '0;
    assign bus_b.offset    = (sel == 1) ? 7'(of) : '0;

    assign bus_c.start = (sel == 2) && st;  assign bus_c.halt   = (sel == 2) && ha;
    assign bus_c.en    = (sel == 2) && en;  assign bus_c.hold   = (sel == 2) && ho;
    assign bus_c.load  = (sel == 2) && ld;  assign bus_c.branch = (sel == 2) && br;
    assign bus_c.load_addr = (sel == 2) ? 6'(la) : '0;
    assign bus_c.offset    = (sel == 2) ? 7'(of) : '0;

    logic [9:0] obs_pc;
    logic [7:0] obs_line;
    logic       obs_run, obs_wrap, obs_done, obs_fault;

    always_comb begin
        obs_pc = bus_a.pc; obs_line = bus_a.line; obs_run = bus_a.running;
        obs_wrap = bus_a.wrap; obs_done = bus_a.done; obs_fault = bus_a.fault;
        if (sel == 1) begin
            obs_pc = 10'(bus_b.pc); obs_line = 8'(bus_b.line); obs_run = bus_b.running;
            obs_wrap = bus_b.wrap; obs_done = bus_b.done; obs_fault = bus_b.fault;
        end else if (sel == 2) begin
            obs_pc = 10'(bus_c.pc); obs_line = 8'(bus_c.line); obs_run = bus_c.running;
            obs_wrap = bus_c.wrap; obs_done = bus_c.done; obs_fault = bus_c.fault;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic h, input logic e, input logic hd,
                         input logic l, input logic [9:0] a, input logic b, input logic [10:0] o);
        st = s; ha = h; en = e; ho = hd; ld = l; la = a; br = b; of = o;
    endtask

    // Push the expected post-edge state, clock once, then pop and compare.
    task automatic cycle(input string tag, input logic [9:0] pc, input logic run,
                         input logic wr, input logic dn, input logic flt);
        exp_t  e;
        string t;
        e = '{pc: pc, run: run, wrap: wr, done: dn, fault: flt};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, '0, 0, '0);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_val({t, ".pc"},      32'(obs_pc),    32'(e.pc));
        check_val({t, ".line"},    32'(obs_line),  32'(e.pc >> 2));
        check_val({t, ".running"}, 32'(obs_run),   32'(e.run));
        check_val({t, ".wrap"},    32'(obs_wrap),  32'(e.wrap));
        check_val({t, ".done"},    32'(obs_done),  32'(e.done));
        check_val({t, ".fault"},   32'(obs_fault), 32'(e.fault));
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, ".pc"},      32'(obs_pc),    32'd0);
        check_val({tag, ".running"}, 32'(obs_run),   32'd0);
        check_val({tag, ".wrap"},    32'(obs_wrap),  32'd0);
        check_val({tag, ".done"},    32'(obs_done),  32'd0);
        check_val({tag, ".fault"},   32'(obs_fault), 32'd0);
    endtask

    initial begin
        sel = 0;
        drive(0, 0, 0, 0, 0, '0, 0, '0);
        #1 rst = 1'b1;
        #1 check_reset("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Default config: idle ignores en, run to 0x40, then async reset mid-run.
        drive(0, 0, 1, 0, 0, '0, 0, '0); cycle("idle_en", 10'd0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, '0, 0, '0); cycle("start_a", 10'd0, 1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            drive(0, 0, 1, 0, 0, '0, 0, '0); cycle("run_a", 10'(i * 4), 1, 0, 0, 0);
        end
        rst = 1'b1;
        #1 check_reset("mid_rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // Full sweep of 256 lines: wrap pulses exactly when pc returns to 0.
        drive(1, 0, 0, 0, 0, '0, 0, '0); cycle("restart_a", 10'd0, 1, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            drive(0, 0, 1, 0, 0, '0, 0, '0);
            cycle("sweep_a", 10'((i + 1) * 4), 1, (i == 255), 0, 0);
        end
        drive(0, 0, 1, 0, 0, '0, 0, '0); cycle("post_wrap", 10'd4, 1, 0, 0, 0);

        // Load alignment, negative branch, and priority of load over branch/en.
        drive(0, 0, 0, 0, 1, 10'h107, 0, '0);   cycle("load_107", 10'h104, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, '0, 1, 11'h7F8);   cycle("br_m8", 10'h0FC, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 10'h020, 1, 11'd8); cycle("ld_wins", 10'h020, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0, '0, 0, '0); cycle("hold_en", 10'h020, 1, 0, 0, 0);
        end
        drive(0, 1, 0, 1, 0, '0, 0, '0); cycle("hold_halt", 10'h020, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, '0, 0, '0); cycle("halt", 10'h020, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 10'h0, 0, '0); cycle("halted_ign", 10'h020, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, '0, 0, '0); cycle("restart2", 10'd0, 1, 0, 0, 0);

        // WRAP=0, 10 lines: stepping off the last line halts with pc held at 36.
        sel = 1;
        drive(1, 0, 0, 0, 0, '0, 0, '0); cycle("start_b", 10'd0, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            drive(0, 0, 1, 0, 0, '0, 0, '0); cycle("run_b", 10'(i * 4), 1, 0, 0, 0);
        end
        drive(0, 0, 1, 0, 0, '0, 0, '0); cycle("end_b", 10'd36, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0, '0, 0, '0); cycle("after_b", 10'd36, 0, 0, 0, 0);

        // 10 lines, out-of-range branch targets.
        sel = 2;
        drive(1, 0, 0, 0, 0, '0, 0, '0);        cycle("start_c", 10'd0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 10'd32, 0, '0);    cycle("load_c", 10'd32, 1, 0, 0, 0);
`ifdef PC_BOUNDS_CHECK_EN
        drive(0, 0, 0, 0, 0, '0, 1, 11'd16);    cycle("br_oor_hi", 10'd32, 0, 0, 1, 1);
        drive(0, 0, 1, 0, 0, '0, 0, '0);        cycle("fault_sticky", 10'd32, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, '0, 0, '0);        cycle("start_clr", 10'd0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, '0, 1, 11'h7F0);   cycle("br_oor_lo", 10'd0, 0, 0, 1, 1);
`else
        drive(0, 0, 0, 0, 0, '0, 1, 11'd16);    cycle("br_mod_hi", 10'd8, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, '0, 1, 11'h7F0);   cycle("br_mod_lo", 10'd32, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, '0, 0, '0);        cycle("run_start", 10'd32, 1, 0, 0, 0);
`endif

        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
